// File: rtl/event_packetizer.sv
// Event packetizer: pops 64-bit DVS events from a FIFO, discards events whose
// coordinates fall outside the sensor frame, and emits each kept event as two RAVENS words.
module event_packetizer #(
  parameter int DVS_WIDTH_PXLS  = 346,
  parameter int DVS_HEIGHT_PXLS = 260,
  parameter int EVENT_BITS      = 64,
  parameter int RAVENS_PKT_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       queue_empty,
  output logic                       queue_rd_en,
  input  logic [EVENT_BITS-1:0]      queue_rd_data,
  output logic [RAVENS_PKT_BITS-1:0] pkt_data,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic                       pkt_last,
  output logic [15:0]                drop_count
);

  localparam int TS_BITS    = 45;
  localparam int COORD_BITS = 9;
  localparam int Y_LSB      = TS_BITS + 1;
  localparam int X_LSB      = Y_LSB + COORD_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, SEND_HI, SEND_LO} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [EVENT_BITS-1:0] r_event;
  logic [15:0]           r_drop_count;
  logic [COORD_BITS-1:0] w_in_x;
  logic [COORD_BITS-1:0] w_in_y;
  logic                  w_out_of_range;
  logic                  w_can_fetch;
  logic [31:0]           w_word_hi;
  logic [31:0]           w_word_lo;

  assign w_in_x = queue_rd_data[X_LSB +: COORD_BITS];
  assign w_in_y = queue_rd_data[Y_LSB +: COORD_BITS];
  assign w_out_of_range = (32'(w_in_x) >= 32'(DVS_WIDTH_PXLS)) ||
                          (32'(w_in_y) >= 32'(DVS_HEIGHT_PXLS));

  // Gating the pop with rst keeps the first fetch after the reset is released.
  assign w_can_fetch = en && !queue_empty && !rst;

  assign w_word_hi = {r_event[X_LSB +: COORD_BITS], r_event[Y_LSB +: COORD_BITS],
                      r_event[TS_BITS], r_event[TS_BITS-1:32]};
  assign w_word_lo = r_event[31:0];
  assign drop_count = r_drop_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_event      <= '0;
      r_drop_count <= '0;
    end else if (r_state == FETCH) begin
      r_event <= queue_rd_data;
      if (w_out_of_range && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // NOTE: every combinational output gets a default first, otherwise paths
  // that skip an assignment infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_can_fetch) w_next_state = FETCH;
      FETCH:   w_next_state = w_out_of_range ? IDLE : SEND_HI;
      SEND_HI: if (pkt_ready) w_next_state = SEND_LO;
      SEND_LO: if (pkt_ready) w_next_state = w_can_fetch ? FETCH : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    queue_rd_en = 1'b0;
    pkt_valid   = 1'b0;
    pkt_last    = 1'b0;
    pkt_data    = '0;
    case (r_state)
      IDLE: queue_rd_en = w_can_fetch;
      SEND_HI: begin
        pkt_valid = 1'b1;
        pkt_data  = RAVENS_PKT_BITS'(w_word_hi);
      end
      SEND_LO: begin
        pkt_valid   = 1'b1;
        pkt_last    = 1'b1;
        pkt_data    = RAVENS_PKT_BITS'(w_word_lo);
        queue_rd_en = w_can_fetch && pkt_ready;
      end
      default: ;
    endcase
    // Nothing is offered during a reset cycle, so an interrupted event never completes.
    if (rst) begin
      pkt_valid = 1'b0;
      pkt_last  = 1'b0;
      pkt_data  = '0;
    end
  end

endmodule
